// File: rtl/fifo_ctrl.sv
// First-word-fall-through FIFO controller sequencing an external fifo_memory
// (registered read, 1-cycle latency). Optional watermark flags: FIFO_CTRL_WATERMARK_EN.
`timescale 1ns/1ps

module fifo_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
`ifdef FIFO_CTRL_WATERMARK_EN
    ,
    parameter int AF_LEVEL   = (2 ** ADDR_WIDTH) - 2,
    parameter int AE_LEVEL   = 1
`endif
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  mem_wen,
    output logic [ADDR_WIDTH-1:0] mem_waddr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  mem_ren,
    output logic [ADDR_WIDTH-1:0] mem_raddr,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic [ADDR_WIDTH:0]   count
`ifdef FIFO_CTRL_WATERMARK_EN
    ,
    output logic                  almost_full,
    output logic                  almost_empty
`endif
);

    localparam logic [ADDR_WIDTH:0] FULL_LVL = (ADDR_WIDTH+1)'(1) << ADDR_WIDTH;

    logic [ADDR_WIDTH-1:0] wptr;
    logic [ADDR_WIDTH-1:0] rptr;
    logic [ADDR_WIDTH:0]   mcnt;
    logic [ADDR_WIDTH:0]   mcnt_next;
    logic                  ovld;
    logic                  ovld_next;
    logic                  push;
    logic                  fetch;
    logic                  pop;

    // NOTE: every signal written here gets a default first so no latch is inferred.
    always_comb begin
        in_ready  = !rst && (mcnt != FULL_LVL);
        push      = in_valid && in_ready;
        fetch     = !rst && (mcnt != '0) && (!ovld || out_ready);
        pop       = ovld && out_ready;

        ovld_next = ovld;
        if (fetch)
            ovld_next = 1'b1;
        else if (pop)
            ovld_next = 1'b0;

        mcnt_next = mcnt;
        case ({push, fetch})
            2'b10:   mcnt_next = mcnt + 1'b1;
            2'b01:   mcnt_next = mcnt - 1'b1;
            default: mcnt_next = mcnt;
        endcase
    end

    // The memory's registered rdata is the output stage; ovld says whether it is live.
    assign mem_wen   = push;
    assign mem_waddr = wptr;
    assign mem_wdata = in_data;
    assign mem_ren   = fetch;
    assign mem_raddr = rptr;
    assign out_valid = ovld;
    assign out_data  = mem_rdata;
    assign count     = mcnt + {{ADDR_WIDTH{1'b0}}, ovld};

    // NOTE: state uses non-blocking assignments; memory contents live outside and are never reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
            mcnt <= '0;
            ovld <= 1'b0;
        end else begin
            if (push)
                wptr <= wptr + 1'b1;
            if (fetch)
                rptr <= rptr + 1'b1;
            mcnt <= mcnt_next;
            ovld <= ovld_next;
        end
    end

`ifdef FIFO_CTRL_WATERMARK_EN
    logic [ADDR_WIDTH:0] count_next;

    assign count_next = mcnt_next + {{ADDR_WIDTH{1'b0}}, ovld_next};

    // Flags track the occupancy the FIFO will hold after this edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
        end else begin
            almost_full  <= (int'(count_next) >= AF_LEVEL);
            almost_empty <= (int'(count_next) <= AE_LEVEL);
        end
    end
`endif

endmodule

// File: tb/tb_fifo_ctrl.sv
// Scoreboard bench for fifo_ctrl with a behavioural fifo_memory model alongside.
`timescale 1ns/1ps

module tb_fifo_ctrl;

    localparam int DW    = 8;
    localparam int AW    = 4;
    localparam int DEPTH = 2 ** AW;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          mem_wen;
    logic [AW-1:0] mem_waddr;
    logic [DW-1:0] mem_wdata;
    logic          mem_ren;
    logic [AW-1:0] mem_raddr;
    logic [DW-1:0] mem_rdata;
    logic [AW:0]   count;
`ifdef FIFO_CTRL_WATERMARK_EN
    logic          almost_full;
    logic          almost_empty;
`endif

    int n_checks = 0;
    int n_pass   = 0;
    int n_pops   = 0;
    logic [DW-1:0] sb[$];

    always #5 clk = ~clk;

    fifo_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .mem_wen   (mem_wen),
        .mem_waddr (mem_waddr),
        .mem_wdata (mem_wdata),
        .mem_ren   (mem_ren),
        .mem_raddr (mem_raddr),
        .mem_rdata (mem_rdata),
        .count     (count)
`ifdef FIFO_CTRL_WATERMARK_EN
        ,
        .almost_full  (almost_full),
        .almost_empty (almost_empty)
`endif
    );

    // fifo_memory stand-in: synchronous write, registered read, contents never reset.
    logic [DW-1:0] mem [DEPTH];
    always @(posedge clk) begin
        if (mem_wen)
            mem[mem_waddr] <= mem_wdata;
        if (mem_ren)
            mem_rdata <= mem[mem_raddr];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp)
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        else
            n_pass++;
    endtask

    // Recorder: every accepted word becomes an expected output, in acceptance order.
    always @(negedge clk) begin
        #1;
        if (!rst && in_valid && in_ready)
            sb.push_back(in_data);
    end

    // Monitor: occupancy must match the scoreboard; the presented word must be the oldest one.
    always @(negedge clk) begin
        if (!rst) begin
            check("count_vs_sb", 32'(count), 32'(sb.size()));
            if (out_valid) begin
                if (sb.size() == 0) begin
                    check("unexpected_out", 32'(out_data), 32'hFFFF_FFFF);
                end else begin
                    check("out_data", 32'(out_data), 32'(sb[0]));
                    if (out_ready) begin
                        void'(sb.pop_front());
                        n_pops++;
                    end
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [DW-1:0] d, input logic r);
        in_valid  = v;
        in_data   = d;
        out_ready = r;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        sb.delete();
        cyc();
        rst = 1'b0;
    endtask

    // Waits for count to reach target, sampled on the falling edge, within a cycle budget.
    task automatic wait_count(input int target, input int budget, input string name);
        int n;
        n = 0;
        @(negedge clk);
        while (int'(count) != target && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(count), 32'(target));
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b0, '0, 1'b0);
        cyc();
        cyc();
        rst = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_count", 32'(count), 0);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_in_ready", 32'(in_ready), 1);

        // Single push: write strobe at t, out_valid visible two edges later
        cyc();
        drive(1'b1, 8'hA5, 1'b0);
        @(negedge clk);
        check("t0_mem_wen", 32'(mem_wen), 1);
        check("t0_mem_waddr", 32'(mem_waddr), 0);
        cyc();
        drive(1'b0, 8'h00, 1'b0);
        @(negedge clk);
        check("t1_out_valid", 32'(out_valid), 0);
        check("t1_count", 32'(count), 1);
        cyc();
        @(negedge clk);
        check("t2_out_valid", 32'(out_valid), 1);
        check("t2_out_data", 32'(out_data), 32'hA5);
        check("t2_count", 32'(count), 1);

        // Fill to DEPTH+1, then drain one per cycle
        do_reset();
        for (int i = 0; i <= DEPTH; i++) begin
            drive(1'b1, DW'(i), 1'b0);
            cyc();
        end
        drive(1'b1, 8'hEE, 1'b0);
        @(negedge clk);
        check("full_in_ready", 32'(in_ready), 0);
        check("full_count", 32'(count), DEPTH + 1);
        cyc();
        cyc();
        drive(1'b0, 8'h00, 1'b1);
        for (int i = 0; i <= DEPTH; i++)
            cyc();
        @(negedge clk);
        check("drain_count", 32'(count), 0);
        check("drain_out_valid", 32'(out_valid), 0);

        // Streaming 100 words with both sides ready; pointers wrap six times
        do_reset();
        n_pops = 0;
        for (int i = 0; i < 100; i++) begin
            drive(1'b1, DW'(8'h40 + i), 1'b1);
            cyc();
        end
        drive(1'b0, 8'h00, 1'b1);
        cyc();
        cyc();
        @(negedge clk);
        check("stream_pops", 32'(n_pops), 100);
        check("stream_count", 32'(count), 0);

        // Random handshakes
        do_reset();
        for (int i = 0; i < 2000; i++) begin
            drive(1'($urandom_range(0, 1)), DW'($urandom), 1'($urandom_range(0, 1)));
            cyc();
        end
        drive(1'b0, 8'h00, 1'b1);
        wait_count(0, 4 * DEPTH, "random_drain");

        // Reset in the middle of a fill
        do_reset();
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, DW'(8'h90 + i), 1'b0);
            cyc();
        end
        rst = 1'b1;
        sb.delete();
        drive(1'b1, 8'h77, 1'b0);
        @(negedge clk);
        check("midrst_in_ready", 32'(in_ready), 0);
        check("midrst_out_valid", 32'(out_valid), 0);
        check("midrst_count", 32'(count), 0);
        check("midrst_mem_wen", 32'(mem_wen), 0);
        cyc();
        rst = 1'b0;
        drive(1'b1, 8'h3C, 1'b0);
        @(negedge clk);
        check("postrst_count", 32'(count), 0);
        cyc();
        drive(1'b0, 8'h00, 1'b0);
        begin
            int n;
            n = 0;
            @(negedge clk);
            while (!out_valid && n < 8) begin
                @(negedge clk);
                n++;
            end
            check("postrst_out_valid", 32'(out_valid), 1);
            check("postrst_first", 32'(out_data), 32'h3C);
        end
        cyc();
        drive(1'b0, 8'h00, 1'b1);
        wait_count(0, 8, "postrst_drain");

`ifdef FIFO_CTRL_WATERMARK_EN
        // Watermarks with default levels (14 / 1)
        do_reset();
        @(negedge clk);
        check("wm_rst_ae", 32'(almost_empty), 1);
        check("wm_rst_af", 32'(almost_full), 0);
        cyc();
        for (int i = 0; i < DEPTH - 2; i++) begin
            drive(1'b1, DW'(i), 1'b0);
            cyc();
        end
        drive(1'b0, 8'h00, 1'b0);
        @(negedge clk);
        check("wm_count14", 32'(count), DEPTH - 2);
        check("wm_af", 32'(almost_full), 1);
        check("wm_ae_low", 32'(almost_empty), 0);
        cyc();
        drive(1'b0, 8'h00, 1'b1);
        for (int i = 0; i < DEPTH - 3; i++)
            cyc();
        drive(1'b0, 8'h00, 1'b0);
        @(negedge clk);
        check("wm_count1", 32'(count), 1);
        check("wm_ae", 32'(almost_empty), 1);
        check("wm_af_low", 32'(almost_full), 0);
        cyc();
        drive(1'b0, 8'h00, 1'b1);
        wait_count(0, 8, "wm_drain");
`endif

        cyc();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
